// File: rtl/jump_arc_responder_if.sv
// Launch handshake and arc results between the jump FSM (master) and the arc responder (slave).
interface jump_arc_responder_if;
  logic        i_tick;
  logic        i_en;
  logic [10:0] i_v_init;
  logic [8:0]  o_height;
  logic [10:0] o_dist;
  logic        o_done;
  logic        o_busy;

  modport master (
    output i_tick, i_en, i_v_init,
    input  o_height, o_dist, o_done, o_busy
  );

  modport slave (
    input  i_tick, i_en, i_v_init,
    output o_height, o_dist, o_done, o_busy
  );
endinterface

// File: rtl/jump_arc_responder.sv
// Integrates a parabolic jump arc one step per i_tick and reports height, distance and landing.
// All outputs registered: a tick sampled at edge N is visible in cycle N+1; abort on i_en low beats a tick.
module jump_arc_responder #(
  parameter int FRAC_BITS = 5,
  parameter int GRAVITY   = 1,
  parameter int DIST_STEP = 1
) (
  input logic clk_machine,
  input logic rst_machine,
  jump_arc_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FLY, DONE} state_t;

  state_t             state;
  logic signed [12:0] vy;
  logic signed [22:0] acc;
  logic [12:0]        dacc;

  logic signed [23:0] acc_n;
  logic signed [23:0] hgt_n;
  logic [13:0]        dacc_n;
  logic [8:0]         height_sat;
  logic [10:0]        dist_sat;

  // One guard bit on the accumulator sum keeps the landing sign test exact.
  always_comb begin
    acc_n      = {acc[22], acc} + {{11{vy[12]}}, vy};
    hgt_n      = acc_n >>> FRAC_BITS;
    height_sat = (hgt_n > 24'sd511) ? 9'd511 : hgt_n[8:0];
    dacc_n     = {1'b0, dacc} + 14'(DIST_STEP);
    dist_sat   = (dacc_n > 14'd2047) ? 11'd2047 : dacc_n[10:0];
  end

  always_ff @(posedge clk_machine) begin
    if (rst_machine) begin
      state        <= IDLE;
      vy           <= '0;
      acc          <= '0;
      dacc         <= '0;
      bus.o_height <= '0;
      bus.o_dist   <= '0;
      bus.o_done   <= 1'b0;
      bus.o_busy   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.i_en) begin
            vy           <= {2'b00, bus.i_v_init};
            acc          <= '0;
            dacc         <= '0;
            bus.o_height <= '0;
            bus.o_dist   <= '0;
            bus.o_busy   <= 1'b1;
            state        <= FLY;
          end
        end
        FLY: begin
          if (!bus.i_en) begin
            bus.o_height <= '0;
            bus.o_dist   <= '0;
            bus.o_busy   <= 1'b0;
            state        <= IDLE;
          end else if (bus.i_tick) begin
            vy         <= vy - 13'(GRAVITY);
            dacc       <= dacc_n[13] ? '1 : dacc_n[12:0];
            bus.o_dist <= dist_sat;
            if (acc_n <= 24'sd0) begin
              acc          <= '0;
              bus.o_height <= '0;
              bus.o_done   <= 1'b1;
              bus.o_busy   <= 1'b0;
              state        <= DONE;
            end else begin
              acc          <= acc_n[22:0];
              bus.o_height <= height_sat;
            end
          end
        end
        DONE: begin
          // Relaunch only after i_en has been seen low, so hold here while it stays high.
          if (!bus.i_en) begin
            bus.o_done <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jump_arc_responder.sv
// Randomized bench for jump_arc_responder against a closed-form arc model.
module tb_jump_arc_responder;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  jump_arc_responder_if bus();

  jump_arc_responder dut (
    .clk_machine(clk),
    .rst_machine(rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: height from the closed form acc(k) = k*v - k(k-1)/2 after k ticks.
  int     m_st = 0;
  longint m_k = 0;
  longint m_v = 0;
  longint m_a = 0;
  int     m_h = 0;
  int     m_d = 0;
  bit     m_done = 0;
  bit     m_busy = 0;
  bit     armed = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_st = 0; m_h = 0; m_d = 0; m_done = 0; m_busy = 0; armed = 1;
    end else begin
      case (m_st)
        0: if (bus.i_en) begin
          m_st = 1; m_k = 0; m_v = longint'(bus.i_v_init);
          m_h = 0; m_d = 0; m_busy = 1;
        end
        1: if (!bus.i_en) begin
          m_st = 0; m_h = 0; m_d = 0; m_busy = 0;
        end else if (bus.i_tick) begin
          m_k = m_k + 1;
          m_a = m_k * m_v - (m_k * (m_k - 1)) / 2;
          m_d = (m_k > 2047) ? 2047 : int'(m_k);
          if (m_a <= 0) begin
            m_st = 2; m_h = 0; m_done = 1; m_busy = 0;
          end else begin
            m_h = (m_a / 32 > 511) ? 511 : int'(m_a / 32);
          end
        end
        default: if (!bus.i_en) begin
          m_st = 0; m_done = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("height", 32'(bus.o_height), 32'(m_h));
      check("dist",   32'(bus.o_dist),   32'(m_d));
      check("done",   32'(bus.o_done),   32'(m_done));
      check("busy",   32'(bus.o_busy),   32'(m_busy));
    end
  end

  int hist_h[0:4200];
  int hist_d[0:4200];
  int land_tick;
  bit saw_height;

  task automatic step(input bit t);
    bus.i_tick = t;
    @(posedge clk);
    #1;
    bus.i_tick = 1'b0;
  endtask

  task automatic launch(input int v);
    bus.i_v_init = 11'(v);
    bus.i_en     = 1'b1;
    step(1'b0);
    check("launch_busy", 32'(bus.o_busy), 32'd1);
  endtask

  // gap < 0 picks 0..3 idle cycles before each tick; stop_at > 0 returns just before that tick.
  task automatic fly(input int v, input int gap, input int stop_at);
    land_tick  = -1;
    saw_height = 1'b0;
    for (int n = 1; n <= 2 * v + 20; n++) begin
      if (stop_at > 0 && n == stop_at) return;
      repeat (gap < 0 ? $urandom_range(3, 0) : gap) step(1'b0);
      step(1'b1);
      hist_h[n] = int'(bus.o_height);
      hist_d[n] = int'(bus.o_dist);
      if (bus.o_height != 0) saw_height = 1'b1;
      if (bus.o_done) begin
        land_tick = n;
        return;
      end
    end
  endtask

  task automatic release_en();
    bus.i_en = 1'b0;
    step(1'b0);
    check("release_done", 32'(bus.o_done), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_en = 1'b0;
    bus.i_tick = 1'b0;
    bus.i_v_init = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_height", 32'(bus.o_height), 32'd0);
    check("rst_dist",   32'(bus.o_dist),   32'd0);
    check("rst_done",   32'(bus.o_done),   32'd0);
    check("rst_busy",   32'(bus.o_busy),   32'd0);
    rst = 1'b0;
    step(1'b0);

    // v=127, ticks every 4 cycles, then a long hold in DONE.
    launch(127);
    fly(127, 3, 0);
    check("v127_peak_t127", 32'(hist_h[127]), 32'd254);
    check("v127_peak_t128", 32'(hist_h[128]), 32'd254);
    check("v127_land_tick", 32'(land_tick), 32'd255);
    check("v127_land_dist", 32'(hist_d[255]), 32'd255);
    check("v127_land_h",    32'(hist_h[255]), 32'd0);
    for (int i = 0; i < 100; i++) begin
      repeat ($urandom_range(2, 0)) step(1'b0);
      step(1'b1);
    end
    check("hold_done", 32'(bus.o_done), 32'd1);
    check("hold_dist", 32'(bus.o_dist), 32'd255);
    release_en();
    check("release_dist_kept", 32'(bus.o_dist), 32'd255);

    // v=0 with back-to-back ticks.
    launch(0);
    fly(0, 0, 0);
    check("v0_land_tick", 32'(land_tick), 32'd1);
    check("v0_dist", 32'(hist_d[1]), 32'd1);
    check("v0_never_high", 32'(saw_height), 32'd0);
    release_en();

    // v=2047: height and distance saturation.
    launch(2047);
    fly(2047, 0, 0);
    check("v2047_h_t8",  32'(hist_h[8]), 32'd510);
    check("v2047_h_t9",  32'(hist_h[9]), 32'd511);
    check("v2047_h_peak", 32'(hist_h[2047]), 32'd511);
    check("v2047_d_t2046", 32'(hist_d[2046]), 32'd2046);
    check("v2047_d_t2047", 32'(hist_d[2047]), 32'd2047);
    check("v2047_d_t3000", 32'(hist_d[3000]), 32'd2047);
    check("v2047_land_tick", 32'(land_tick), 32'd4095);
    release_en();

    // v=100, abort coincident with tick 50.
    launch(100);
    fly(100, 1, 50);
    check("abort_pre_dist", 32'(bus.o_dist), 32'd49);
    bus.i_en = 1'b0;
    step(1'b1);
    check("abort_height", 32'(bus.o_height), 32'd0);
    check("abort_dist",   32'(bus.o_dist),   32'd0);
    check("abort_done",   32'(bus.o_done),   32'd0);
    check("abort_busy",   32'(bus.o_busy),   32'd0);

    // Reset at tick 30 of v=127, then fresh launch with i_en still high.
    launch(127);
    fly(127, -1, 30);
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    check("midrst_height", 32'(bus.o_height), 32'd0);
    check("midrst_dist",   32'(bus.o_dist),   32'd0);
    check("midrst_busy",   32'(bus.o_busy),   32'd0);
    step(1'b0);
    check("relaunch_busy", 32'(bus.o_busy), 32'd1);
    fly(127, -1, 0);
    check("relaunch_land_tick", 32'(land_tick), 32'd255);
    release_en();

    // Random flights, some aborted part-way.
    for (int r = 0; r < 8; r++) begin
      int v;
      v = $urandom_range(200, 0);
      launch(v);
      if ($urandom_range(2, 0) == 0) begin
        fly(v, -1, $urandom_range(2 * v + 1, 1));
        bus.i_en = 1'b0;
        step(1'($urandom_range(1, 0)));
        check("rand_abort_busy", 32'(bus.o_busy), 32'd0);
      end else begin
        fly(v, -1, 0);
        check("rand_land_tick", 32'(land_tick), 32'(2 * v + 1));
        repeat ($urandom_range(5, 0)) step(1'($urandom_range(1, 0)));
        release_en();
      end
      repeat ($urandom_range(3, 0)) step(1'($urandom_range(1, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
